// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared defaults and types for the data-memory arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int unsigned c_DATA_W  = 16;
    localparam int unsigned c_ADDR_W  = 3;
    localparam int unsigned c_STALL_W = 8;

    // Which side was granted most recently (round-robin memory)
    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Arbiter state: normal round-robin or host-locked burst
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Single-port synchronous RAM, one-cycle registered read.
//            Contents are deliberately not reset so preloaded data survives.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write on an enabled write cycle, otherwise capture the addressed word
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the data RAM between the CPU (lw/sw) and a host/debug
//            port. Round-robin on contention, host lock for bursts,
//            per-port read-data steering and a saturating CPU stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W,
    parameter int ADDR_W  = c_ADDR_W,
    parameter int STALL_W = c_STALL_W
) (
    input  logic               clk,
    input  logic               reset,
    // CPU side
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [DATA_W-1:0]  cpu_rdata,
    // Host side
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    input  logic               host_lock,
    output logic               host_gnt,
    output logic               host_rvalid,
    output logic [DATA_W-1:0]  host_rdata,
    // Status
    output logic               locked,
    output logic [STALL_W-1:0] cpu_stall_cnt
);

    arb_state_t         r_state;
    owner_t             r_last_owner;
    logic               r_cpu_rvalid;
    logic               r_host_rvalid;
    logic [DATA_W-1:0]  r_cpu_rdata;
    logic [DATA_W-1:0]  r_host_rdata;
    logic [STALL_W-1:0] r_stall_cnt;

    logic               w_cpu_gnt;
    logic               w_host_gnt;
    logic               w_lock_hold;
    logic               w_mem_en;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0]  w_mem_wdata;
    logic [DATA_W-1:0]  w_mem_rdata;
    logic               w_cpu_rvalid;
    logic               w_host_rvalid;

    // Lock only persists while the host keeps host_lock high; dropping it
    // falls straight back to normal arbitration in the same cycle.
    assign w_lock_hold = (r_state == LOCKED) && host_lock;

    // Combinational grant: at most one side per cycle, nothing during reset
    always_comb begin
        w_cpu_gnt  = 1'b0;
        w_host_gnt = 1'b0;
        if (!reset) begin
            if (w_lock_hold) begin
                w_host_gnt = host_req;
            end else if (cpu_req && host_req) begin
                if (r_last_owner == OWN_HOST) begin
                    w_cpu_gnt = 1'b1;
                end else begin
                    w_host_gnt = 1'b1;
                end
            end else begin
                w_cpu_gnt  = cpu_req;
                w_host_gnt = host_req;
            end
        end
    end

    assign cpu_gnt  = w_cpu_gnt;
    assign host_gnt = w_host_gnt;

    // FSM and round-robin history; HOST as reset owner lets the CPU win first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_last_owner <= OWN_HOST;
        end else begin
            if ((w_host_gnt && host_lock) || w_lock_hold) begin
                r_state <= LOCKED;
            end else begin
                r_state <= ARB;
            end
            if (w_cpu_gnt) begin
                r_last_owner <= OWN_CPU;
            end else if (w_host_gnt) begin
                r_last_owner <= OWN_HOST;
            end
        end
    end

    assign locked = (r_state == LOCKED);

    // Steer the granted port onto the single RAM port
    assign w_mem_en    = w_cpu_gnt || w_host_gnt;
    assign w_mem_we    = w_cpu_gnt ? cpu_we    : (w_host_gnt && host_we);
    assign w_mem_addr  = w_cpu_gnt ? cpu_addr  : host_addr;
    assign w_mem_wdata = w_cpu_gnt ? cpu_wdata : host_wdata;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem_array (
        .clk     (clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Remember which port issued a read so only that port sees rvalid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid  <= w_cpu_gnt  && !cpu_we;
            r_host_rvalid <= w_host_gnt && !host_we;
        end
    end

    // Per-port hold registers keep the last read value after rvalid drops
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            if (r_cpu_rvalid) begin
                r_cpu_rdata <= w_mem_rdata;
            end
            if (r_host_rvalid) begin
                r_host_rdata <= w_mem_rdata;
            end
        end
    end

    // A read in flight when reset rises must not surface, so the read
    // outputs are masked by reset just like the grants.
    assign w_cpu_rvalid  = r_cpu_rvalid  && !reset;
    assign w_host_rvalid = r_host_rvalid && !reset;
    assign cpu_rvalid    = w_cpu_rvalid;
    assign host_rvalid   = w_host_rvalid;
    assign cpu_rdata     = reset ? '0 : (w_cpu_rvalid  ? w_mem_rdata : r_cpu_rdata);
    assign host_rdata    = reset ? '0 : (w_host_rvalid ? w_mem_rdata : r_host_rdata);

    // Count CPU wait cycles, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (cpu_req && !w_cpu_gnt && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign cpu_stall_cnt = r_stall_cnt;

endmodule : dmem_arbiter
`default_nettype wire
